// File: rtl/l1i_pkg.sv
// Definitions shared between the L1 instruction cache and its refill responder.
// Address split is TAG/INDEX/OFFSET = 23/5/4 over a 32-bit byte address.
package l1i_pkg;

    localparam int LINE_WORDS  = 4;
    localparam int TAG_W       = 23;
    localparam int INDEX_W     = 5;
    localparam int OFFSET_W    = 4;
    localparam int LINE_ADDR_W = TAG_W + INDEX_W;
    localparam int BEAT_W      = $clog2(LINE_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPT,
        ST_WAIT,
        ST_BEAT,
        ST_DONE
    } state_t;

    // Word address of a given beat within a line.
    function automatic logic [LINE_ADDR_W+BEAT_W-1:0] word_addr(
        input logic [LINE_ADDR_W-1:0] line,
        input logic [BEAT_W-1:0]      beat
    );
        return {line, beat};
    endfunction

endpackage

// File: rtl/l1i_refill_responder.sv
// Serves an L1I line miss by reading four words from a word SRAM and returning
// them as single-cycle beats, with WAIT_CYCLES idle cycles ahead of each beat.
module l1i_refill_responder
    import l1i_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_req,
    input  logic [31:0] I_addr,
    input  logic        axi_valid,
    output logic [31:0] I_out,
    output logic        axi_ready,
    output logic        mem_en,
    output logic [29:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [15:0] line_count
);

    state_t                  r_state;
    logic [BEAT_W-1:0]       r_beat;
    logic [3:0]              r_wait;
    logic [LINE_ADDR_W-1:0]  r_line;
    logic [31:0]             r_data;
    logic [31:0]             r_out;
    logic                    r_axi_ready;
    logic                    r_mem_en;
    logic [29:0]             r_mem_addr;
    logic                    r_busy;
    logic [15:0]             r_line_count;

    // Byte offset within the line carries no information for a whole-line refill.
    logic w_unused_offset;
    assign w_unused_offset = ^I_addr[OFFSET_W-1:0];

    // Outputs are registered: each transition sets the outputs of the state it enters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_beat       <= '0;
            r_wait       <= '0;
            r_line       <= '0;
            r_data       <= '0;
            r_out        <= '0;
            r_axi_ready  <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_addr   <= '0;
            r_busy       <= 1'b0;
            r_line_count <= '0;
        end else begin
            r_out       <= '0;
            r_axi_ready <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (axi_valid && I_req) begin
                        r_line     <= I_addr[31:OFFSET_W];
                        r_beat     <= '0;
                        r_state    <= ST_FETCH;
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= word_addr(I_addr[31:OFFSET_W], '0);
                        r_busy     <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_CAPT;
                end
                ST_CAPT: begin
                    r_data <= mem_rdata;
                    if (WAIT_CYCLES > 0) begin
                        r_wait  <= 4'(WAIT_CYCLES);
                        r_state <= ST_WAIT;
                    end else begin
                        r_state     <= ST_BEAT;
                        r_axi_ready <= 1'b1;
                        r_out       <= mem_rdata;
                    end
                end
                ST_WAIT: begin
                    if (r_wait <= 4'd1) begin
                        r_wait      <= '0;
                        r_state     <= ST_BEAT;
                        r_axi_ready <= 1'b1;
                        r_out       <= r_data;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                ST_BEAT: begin
                    // The beat counter only returns to zero via DONE/IDLE, never by wrapping here.
                    if (r_beat == BEAT_W'(LINE_WORDS - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_beat     <= r_beat + 1'b1;
                        r_state    <= ST_FETCH;
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= word_addr(r_line, r_beat + 1'b1);
                    end
                end
                ST_DONE: begin
                    r_line_count <= r_line_count + 16'd1;
                    r_beat       <= '0;
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign I_out      = r_out;
    assign axi_ready  = r_axi_ready;
    assign mem_en     = r_mem_en;
    assign mem_addr   = r_mem_addr;
    assign busy       = r_busy;
    assign line_count = r_line_count;

endmodule

// File: tb/tb_l1i_refill_responder.sv
// Directed bench for the L1I refill responder: one instance with two wait
// cycles, one with none, each backed by a registered-read SRAM model.
module tb_l1i_refill_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        I_req = 1'b0;
    logic        axi_valid = 1'b0;
    logic [31:0] I_addr = '0;

    logic [31:0] out2, out0, rdata2, rdata0;
    logic        ready2, ready0, en2, en0, busy2, busy0;
    logic [29:0] addr2, addr0;
    logic [15:0] lc2, lc0;

    always #5 clk = ~clk;

    l1i_refill_responder #(.WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .I_req(I_req), .I_addr(I_addr), .axi_valid(axi_valid),
        .I_out(out2), .axi_ready(ready2), .mem_en(en2), .mem_addr(addr2),
        .mem_rdata(rdata2), .busy(busy2), .line_count(lc2)
    );

    l1i_refill_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .I_req(I_req), .I_addr(I_addr), .axi_valid(axi_valid),
        .I_out(out0), .axi_ready(ready0), .mem_en(en0), .mem_addr(addr0),
        .mem_rdata(rdata0), .busy(busy0), .line_count(lc0)
    );

    // SRAM: word n holds 0x1000_0000 + n, data one cycle after the enable
    always @(posedge clk) begin
        if (en2) rdata2 <= 32'h1000_0000 + {2'b00, addr2};
        if (en0) rdata0 <= 32'h1000_0000 + {2'b00, addr0};
    end

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int viol = 0;
    int t0;
    int nb;

    int          bt2[$], bt0[$];
    logic [31:0] bd2[$], bd0[$];
    logic [29:0] ma2[$], ma0[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ready2) begin bt2.push_back(cyc); bd2.push_back(out2); end
        if (ready0) begin bt0.push_back(cyc); bd0.push_back(out0); end
        if (en2) ma2.push_back(addr2);
        if (en0) ma0.push_back(addr0);
        if (!ready2 && out2 != 32'd0) viol++;
        if (!ready0 && out0 != 32'd0) viol++;
        if (!en2 && addr2 != 30'd0) viol++;
        if (!en0 && addr0 != 30'd0) viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic clear_q();
        bt2.delete(); bd2.delete(); ma2.delete();
        bt0.delete(); bd0.delete(); ma0.delete();
    endtask

    // Four beats at T+3+W+k*(3+W), data and SRAM addresses ascending from a0
    task automatic check_line(input bit sel0, input string tag, input int t, input int w,
                              input logic [29:0] a0);
        int          tm;
        logic [31:0] dv;
        logic [29:0] av;
        check($sformatf("%s beat count", tag), sel0 ? bt0.size() : bt2.size(), 4);
        check($sformatf("%s fetch count", tag), sel0 ? ma0.size() : ma2.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (sel0) begin
                tm = (k < bt0.size()) ? bt0[k] : -1;
                dv = (k < bd0.size()) ? bd0[k] : 'x;
                av = (k < ma0.size()) ? ma0[k] : 'x;
            end else begin
                tm = (k < bt2.size()) ? bt2[k] : -1;
                dv = (k < bd2.size()) ? bd2[k] : 'x;
                av = (k < ma2.size()) ? ma2[k] : 'x;
            end
            check($sformatf("%s beat%0d cycle", tag, k), tm, t + 3 + w + k * (3 + w));
            check($sformatf("%s beat%0d data", tag, k), dv,
                  32'h1000_0000 + {2'b00, a0 + 30'(k)});
            check($sformatf("%s beat%0d mem_addr", tag, k), {2'b00, av}, {2'b00, a0 + 30'(k)});
        end
    endtask

    task automatic request(input logic [31:0] a);
        t0 = cyc;
        I_req = 1'b1;
        axi_valid = 1'b1;
        I_addr = a;
        @(negedge clk);
        axi_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset axi_ready", ready2, 0);
        check("reset I_out", out2, 0);
        check("reset mem_en", en2, 0);
        check("reset mem_addr", addr2, 0);
        check("reset busy", busy2, 0);
        check("reset line_count", lc2, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // A: two wait cycles, line 0x120, address wiggled while busy
        clear_q();
        request(32'h0000_0120);
        I_addr = 32'hDEAD_BEE0;
        go_to(t0 + 21);
        check("A busy in DONE", busy2, 1);
        go_to(t0 + 22);
        check("A busy after DONE", busy2, 0);
        check("A line_count", lc2, 1);
        check_line(1'b0, "A", t0, 2, 30'h48);
        check("A dut0 line_count", lc0, 1);
        I_req = 1'b0;
        repeat (3) @(negedge clk);

        // B: zero wait cycles, low address bits ignored, I_req drops mid-burst
        clear_q();
        request(32'hFFFF_FFF4);
        go_to(t0 + 4);
        I_req = 1'b0;
        go_to(t0 + 25);
        check_line(1'b1, "B", t0, 0, 30'h3FFF_FFFC);
        check("B line_count", lc0, 2);
        check("B busy", busy0, 0);
        repeat (2) @(negedge clk);

        // C: second request pulse during the burst is ignored
        clear_q();
        request(32'h0000_0340);
        go_to(t0 + 7);
        axi_valid = 1'b1;
        I_addr = 32'h0000_0200;
        @(negedge clk);
        axi_valid = 1'b0;
        go_to(t0 + 30);
        check_line(1'b0, "C", t0, 2, 30'hD0);
        check("C line_count", lc2, 3);
        I_req = 1'b0;
        repeat (2) @(negedge clk);

        // D: reset in the middle of a burst, then a fresh refill
        clear_q();
        request(32'h0000_0120);
        go_to(t0 + 8);
        nb = bt2.size();
        rst = 1'b1;
        #1;
        check("D beats before reset", nb, 1);
        check("D rst axi_ready", ready2, 0);
        check("D rst I_out", out2, 0);
        check("D rst mem_en", en2, 0);
        check("D rst mem_addr", addr2, 0);
        check("D rst busy", busy2, 0);
        check("D rst line_count", lc2, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        go_to(t0 + 35);
        check("D no beats after reset", bt2.size(), 1);
        check("D line_count after reset", lc2, 0);
        clear_q();
        request(32'h0000_0120);
        go_to(t0 + 22);
        check_line(1'b0, "D2", t0, 2, 30'h48);
        check("D2 line_count", lc2, 1);
        I_req = 1'b0;
        repeat (2) @(negedge clk);

        // E: axi_valid without I_req is ignored
        clear_q();
        axi_valid = 1'b1;
        I_addr = 32'h0000_0120;
        @(negedge clk);
        axi_valid = 1'b0;
        check("E busy2", busy2, 0);
        check("E busy0", busy0, 0);
        repeat (5) @(negedge clk);
        check("E dut2 fetches", ma2.size(), 0);
        check("E dut0 fetches", ma0.size(), 0);
        check("E line_count", lc2, 1);

        check("idle outputs nonzero", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
